// File: rtl/grey_conv_pkg.sv
// -----------------------------------------------------------------------------
// grey_conv_pkg
// Shared types and constants for the grey_conv colour-to-greyscale stage:
//   - mode_e       : conversion mode encoding (bypass, BT.601 luma, average,
//                    reserved; reserved behaves as bypass)
//   - COEF_*       : Q8 weights for luma (77/150/29) and average (85)
//   - ROUND        : half-LSB added before the >>8 truncation
//   - LAT          : end-to-end pipeline depth in pixel clocks
//   - DATA_W/COEF_W: per-channel pixel width and coefficient width
// -----------------------------------------------------------------------------
package grey_conv_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_LUMA   = 2'd1,
    MODE_AVG    = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  localparam int DATA_W   = 8;
  localparam int COEF_W   = 8;

  localparam int COEF_R   = 77;
  localparam int COEF_G   = 150;
  localparam int COEF_B   = 29;
  localparam int COEF_AVG = 85;
  localparam int ROUND    = 128;

  localparam int LAT      = 3;

endpackage

// File: rtl/grey_mac.sv
// -----------------------------------------------------------------------------
// grey_mac
// Weighted-sum datapath for grey_conv (pipeline stages 1 and 2).
// Stage 1 registers the pixel; the 8x8 products and the channel sum are formed
// from the registered pixel. Stage 2 registers the rounded luma and average
// accumulators together with the original pixel. Latency: 2 clocks.
// Ports:
//   clk    in   pixel clock
//   rst_n  in   asynchronous active-low reset
//   rgb    in   pixel {R, G, B}
//   luma   out  77R + 150G + 29B + 128   (registered, stage 2)
//   avg    out  85(R + G + B) + 128      (registered, stage 2)
//   rgb_d  out  input pixel delayed by 2 clocks
// -----------------------------------------------------------------------------
module grey_mac
  import grey_conv_pkg::*;
#(
  parameter int DATA_W = grey_conv_pkg::DATA_W,
  parameter int COEF_W = grey_conv_pkg::COEF_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [3*DATA_W-1:0]        rgb,
  output logic [DATA_W+COEF_W-1:0]   luma,
  output logic [DATA_W+COEF_W-1:0]   avg,
  output logic [3*DATA_W-1:0]        rgb_d
);

  localparam int ACC_W = DATA_W + COEF_W;
  localparam int SUM_W = DATA_W + 2;

  localparam logic [ACC_W-1:0] K_R   = ACC_W'(COEF_R);
  localparam logic [ACC_W-1:0] K_G   = ACC_W'(COEF_G);
  localparam logic [ACC_W-1:0] K_B   = ACC_W'(COEF_B);
  localparam logic [ACC_W-1:0] K_AVG = ACC_W'(COEF_AVG);
  localparam logic [ACC_W-1:0] K_RND = ACC_W'(ROUND);

  // Worst cases (65408 luma, 65153 average) stay below 2^16, so the
  // rounding add never wraps.
  function automatic logic [ACC_W-1:0] add_round(input logic [ACC_W-1:0] acc);
    return acc + K_RND;
  endfunction

  logic [3*DATA_W-1:0] rgb_p0;
  logic [DATA_W-1:0]   r_p0, g_p0, b_p0;
  logic [ACC_W-1:0]    prod_r, prod_g, prod_b, prod_avg;
  logic [SUM_W-1:0]    sum3;
  logic [ACC_W-1:0]    luma_p1, avg_p1;
  logic [3*DATA_W-1:0] rgb_p1;

  assign r_p0 = rgb_p0[3*DATA_W-1 -: DATA_W];
  assign g_p0 = rgb_p0[2*DATA_W-1 -: DATA_W];
  assign b_p0 = rgb_p0[DATA_W-1:0];

  assign prod_r   = ACC_W'(r_p0) * K_R;
  assign prod_g   = ACC_W'(g_p0) * K_G;
  assign prod_b   = ACC_W'(b_p0) * K_B;
  assign sum3     = SUM_W'(r_p0) + SUM_W'(g_p0) + SUM_W'(b_p0);
  assign prod_avg = ACC_W'(sum3) * K_AVG;

  // ---- Stage 1: register pixel ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_p0 <= '0;
    end else begin
      rgb_p0 <= rgb;
    end
  end

  // ---- Stage 2: rounded accumulators, pixel carried alongside ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      luma_p1 <= '0;
      avg_p1  <= '0;
      rgb_p1  <= '0;
    end else begin
      luma_p1 <= add_round(prod_r + prod_g + prod_b);
      avg_p1  <= add_round(prod_avg);
      rgb_p1  <= rgb_p0;
    end
  end

  assign luma  = luma_p1;
  assign avg   = avg_p1;
  assign rgb_d = rgb_p1;

endmodule

// File: rtl/grey_conv.sv
// -----------------------------------------------------------------------------
// grey_conv
// Colour-to-greyscale pixel stage ahead of the TMDS encoder. Fixed 3-clock
// latency for pixel and timing; one pixel per clock, no backpressure.
// The requested mode is sampled only on the active edge of vsync_i, so a
// frame never mixes modes. The pixel coinciding with that edge still uses
// the previous mode.
// Build option: GREY_CONV_SPLIT_EN -- pixels at x >= H_ACTIVE/2 in a line are
// passed through in colour (split-screen compare); default build converts the
// whole active area.
// Ports:
//   clk_i    in   pixel clock
//   rst_n_i  in   asynchronous active-low reset
//   de_i     in   data enable
//   hsync_i  in   horizontal sync
//   vsync_i  in   vertical sync (active level VSYNC_POL)
//   rgb_i    in   pixel {R[23:16], G[15:8], B[7:0]}
//   mode_i   in   requested mode (0 bypass, 1 luma, 2 average, 3 bypass)
//   de_o     out  de_i delayed 3 clocks
//   hsync_o  out  hsync_i delayed 3 clocks
//   vsync_o  out  vsync_i delayed 3 clocks
//   rgb_o    out  converted pixel, zero while de_o is low
//   mode_o   out  mode currently in effect
// -----------------------------------------------------------------------------
module grey_conv
  import grey_conv_pkg::*;
#(
  parameter logic VSYNC_POL = 1'b1,
  parameter int   H_ACTIVE  = 1280
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        de_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic [23:0] rgb_i,
  input  logic [1:0]  mode_i,
  output logic        de_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic [23:0] rgb_o,
  output logic [1:0]  mode_o
);

  localparam logic [11:0] HALF = 12'(H_ACTIVE / 2);

  function automatic logic [23:0] grey_pix(input logic [15:0] acc);
    return {3{acc[15:8]}};
  endfunction

  mode_e          mode_q, mode_p0, mode_p1;
  logic           vs_edge;
  logic           vld_p0, vld_p1, vld_p2;
  logic [LAT-1:0] hs_dly, vs_dly;
  logic           split_byp, byp_p0, byp_p1;
  logic [15:0]    luma_p1, avg_p1;
  logic [23:0]    rgb_p1, rgb_sel;

  // vs_dly[0] doubles as the registered copy of vsync_i for edge detection.
  assign vs_edge = (vsync_i == VSYNC_POL) && (vs_dly[0] != VSYNC_POL);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mode_q <= MODE_BYPASS;
    end else if (vs_edge) begin
      mode_q <= mode_e'(mode_i);
    end
  end

`ifdef GREY_CONV_SPLIT_EN
  logic [11:0] x_cnt;

  // x_cnt holds the index of the current pixel within its line.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      x_cnt <= '0;
    end else if (!de_i) begin
      x_cnt <= '0;
    end else if (x_cnt != 12'hFFF) begin
      x_cnt <= x_cnt + 12'd1;
    end
  end

  assign split_byp = (x_cnt >= HALF);
`else
  logic unused_half;

  assign unused_half = ^HALF;
  assign split_byp   = 1'b0;
`endif

  grey_mac u_mac (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .rgb   (rgb_i),
    .luma  (luma_p1),
    .avg   (avg_p1),
    .rgb_d (rgb_p1)
  );

  // ---- Stage 1/2: control travelling with the pixel ----
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      mode_p0 <= MODE_BYPASS;
      mode_p1 <= MODE_BYPASS;
      byp_p0  <= 1'b0;
      byp_p1  <= 1'b0;
      hs_dly  <= '0;
      vs_dly  <= {LAT{~VSYNC_POL}};
    end else begin
      vld_p0  <= de_i;
      vld_p1  <= vld_p0;
      mode_p0 <= mode_q;
      mode_p1 <= mode_p0;
      byp_p0  <= split_byp;
      byp_p1  <= byp_p0;
      hs_dly  <= {hs_dly[LAT-2:0], hsync_i};
      vs_dly  <= {vs_dly[LAT-2:0], vsync_i};
    end
  end

  always_comb begin
    rgb_sel = rgb_p1;
    if (!byp_p1) begin
      case (mode_p1)
        MODE_LUMA: rgb_sel = grey_pix(luma_p1);
        MODE_AVG:  rgb_sel = grey_pix(avg_p1);
        default:   rgb_sel = rgb_p1;
      endcase
    end
    if (!vld_p1) begin
      rgb_sel = '0;
    end
  end

  // ---- Stage 3: output select ----
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rgb_o  <= '0;
      vld_p2 <= 1'b0;
    end else begin
      rgb_o  <= rgb_sel;
      vld_p2 <= vld_p1;
    end
  end

  assign de_o    = vld_p2;
  assign hsync_o = hs_dly[LAT-1];
  assign vsync_o = vs_dly[LAT-1];
  assign mode_o  = mode_q;

endmodule

// File: tb/tb_grey_conv.sv
module tb_grey_conv;

`ifdef GREY_CONV_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        de_i, hsync_i, vsync_i;
  logic [23:0] rgb_i;
  logic [1:0]  mode_i;
  logic        de_o, hsync_o, vsync_o;
  logic [23:0] rgb_o;
  logic [1:0]  mode_o;

  int n_chk  = 0;
  int n_fail = 0;

  logic        s_de  [32];
  logic        s_hs  [32];
  logic        s_vs  [32];
  logic [23:0] s_rgb [32];
  logic [23:0] s_exp [32];
  int          n_px = 0;

  grey_conv #(
    .VSYNC_POL (1'b1),
    .H_ACTIVE  (8)
  ) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .de_i    (de_i),
    .hsync_i (hsync_i),
    .vsync_i (vsync_i),
    .rgb_i   (rgb_i),
    .mode_i  (mode_i),
    .de_o    (de_o),
    .hsync_o (hsync_o),
    .vsync_o (vsync_o),
    .rgb_o   (rgb_o),
    .mode_o  (mode_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int k);
    de_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0; rgb_i = 24'h0;
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic vs_pulse(input logic [1:0] m, input string tag);
    de_i = 1'b0; hsync_i = 1'b0; rgb_i = 24'h0;
    mode_i  = m;
    vsync_i = 1'b1;
    tick();
    vsync_i = 1'b0;
    tick();
    chk(tag, mode_o, m);
  endtask

  task automatic add_px(input logic de, input logic hs, input logic vs,
                        input logic [23:0] rgb, input logic [23:0] exp);
    s_de[n_px]  = de;
    s_hs[n_px]  = hs;
    s_vs[n_px]  = vs;
    s_rgb[n_px] = rgb;
    s_exp[n_px] = exp;
    n_px++;
  endtask

  // Pixel j's result is visible after the clock edge following pixel j+2.
  task automatic run_stream(input string tag);
    for (int i = 0; i < n_px + 2; i++) begin
      if (i < n_px) begin
        de_i = s_de[i]; hsync_i = s_hs[i]; vsync_i = s_vs[i]; rgb_i = s_rgb[i];
      end else begin
        de_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0; rgb_i = 24'h5A5A5A;
      end
      tick();
      if (i >= 2) begin
        int j;
        j = i - 2;
        chk($sformatf("%s_rgb%0d", tag, j), rgb_o, s_exp[j]);
        chk($sformatf("%s_de%0d", tag, j), de_o, s_de[j]);
        chk($sformatf("%s_hs%0d", tag, j), hsync_o, s_hs[j]);
        chk($sformatf("%s_vs%0d", tag, j), vsync_o, s_vs[j]);
      end
    end
    n_px = 0;
  endtask

  initial begin
    rst_n_i = 1'b0;
    de_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0; rgb_i = 24'h0; mode_i = 2'd1;
    tick();
    tick();
    chk("rst_de", de_o, 1'b0);
    chk("rst_hs", hsync_o, 1'b0);
    chk("rst_vs", vsync_o, 1'b0);
    chk("rst_rgb", rgb_o, 24'h0);
    chk("rst_mode", mode_o, 2'd0);
    rst_n_i = 1'b1;
    tick();
    chk("rel_mode", mode_o, 2'd0);
    chk("rel_rgb", rgb_o, 24'h0);
    idle(2);

    // Luma
    vs_pulse(2'd1, "latch_luma");
    add_px(1'b0, 1'b1, 1'b0, 24'hFF0000, 24'h000000);
    add_px(1'b1, 1'b0, 1'b0, 24'hFF0000, 24'h4D4D4D);
    add_px(1'b1, 1'b0, 1'b0, 24'hFFFFFF, 24'hFFFFFF);
    add_px(1'b1, 1'b0, 1'b0, 24'h00FF00, 24'h959595);
    add_px(1'b1, 1'b0, 1'b0, 24'h0000FF, 24'h1D1D1D);
    add_px(1'b1, 1'b1, 1'b0, 24'h102030, 24'h1D1D1D);
    run_stream("luma");

    // Average, with blanking
    vs_pulse(2'd2, "latch_avg");
    add_px(1'b1, 1'b0, 1'b0, 24'h102030, 24'h202020);
    add_px(1'b1, 1'b0, 1'b0, 24'hFFFFFF, 24'hFEFEFE);
    add_px(1'b0, 1'b1, 1'b0, 24'hFFFFFF, 24'h000000);
    add_px(1'b1, 1'b0, 1'b0, 24'h000000, 24'h000000);
    run_stream("avg");

    // Reserved mode behaves as bypass
    vs_pulse(2'd3, "latch_rsvd");
    add_px(1'b1, 1'b0, 1'b0, 24'h123456, 24'h123456);
    add_px(1'b0, 1'b0, 1'b0, 24'h123456, 24'h000000);
    add_px(1'b1, 1'b0, 1'b0, 24'hFEDCBA, 24'hFEDCBA);
    run_stream("rsvd");

    // Mid-frame mode request takes effect only at the next vsync edge;
    // the pixel on the edge still uses the old mode.
    vs_pulse(2'd0, "latch_byp");
    mode_i = 2'd1;
    idle(3);
    chk("midframe_mode_hold", mode_o, 2'd0);
    add_px(1'b1, 1'b0, 1'b0, 24'h0000FF, 24'h0000FF);
    add_px(1'b1, 1'b0, 1'b0, 24'h0000FF, 24'h0000FF);
    add_px(1'b1, 1'b0, 1'b1, 24'h0000FF, 24'h0000FF);
    add_px(1'b1, 1'b0, 1'b1, 24'h0000FF, 24'h1D1D1D);
    add_px(1'b1, 1'b0, 1'b0, 24'h0000FF, 24'h1D1D1D);
    run_stream("vs_de");
    chk("midframe_mode_new", mode_o, 2'd1);

    // Split-screen line pair (whole line converted when split is disabled)
    for (int k = 0; k < 8; k++)
      add_px(1'b1, 1'b0, 1'b0, 24'h0000FF, (SPLIT && k >= 4) ? 24'h0000FF : 24'h1D1D1D);
    add_px(1'b0, 1'b1, 1'b0, 24'h0000FF, 24'h000000);
    for (int k = 0; k < 8; k++)
      add_px(1'b1, 1'b0, 1'b0, 24'h0000FF, (SPLIT && k >= 4) ? 24'h0000FF : 24'h1D1D1D);
    run_stream("split");

    // Asynchronous reset mid-line
    vs_pulse(2'd2, "latch_avg2");
    de_i = 1'b1; hsync_i = 1'b1; vsync_i = 1'b0; rgb_i = 24'hFF0000;
    tick(); tick(); tick();
    chk("pre_rst_rgb", rgb_o, 24'h555555);
    chk("pre_rst_hs", hsync_o, 1'b1);
    rst_n_i = 1'b0;
    #1;
    chk("arst_rgb", rgb_o, 24'h0);
    chk("arst_de", de_o, 1'b0);
    chk("arst_hs", hsync_o, 1'b0);
    chk("arst_vs", vsync_o, 1'b0);
    chk("arst_mode", mode_o, 2'd0);
    tick();
    rst_n_i = 1'b1;
    #1;
    chk("post_rst_rgb0", rgb_o, 24'h0);
    tick();
    chk("post_rst_rgb1", rgb_o, 24'h0);
    tick();
    chk("post_rst_rgb2", rgb_o, 24'h0);
    chk("post_rst_de2", de_o, 1'b0);
    tick();
    chk("post_rst_rgb3", rgb_o, 24'hFF0000);
    chk("post_rst_de3", de_o, 1'b1);
    chk("post_rst_mode", mode_o, 2'd0);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
